// File: rtl/eeprom_spi_ctl_pkg.sv
// Shared constants for the serial EEPROM controller.
// Holds the 25xx-series SPI opcodes, top-level FSM state encodings, frame kinds and a small
// helper used to size counters.
// Optional feature macro used by the controller: EEPROM_WIP_POLL_EN.
package eeprom_spi_ctl_pkg;

  // 25xx-series opcodes
  localparam logic [7:0] EE_OP_READ  = 8'h03;
  localparam logic [7:0] EE_OP_WRITE = 8'h02;
  localparam logic [7:0] EE_OP_WREN  = 8'h06;
  localparam logic [7:0] EE_OP_RDSR  = 8'h05;

  // Top FSM states
  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRej   = 3'd1;
  localparam logic [2:0] StSel   = 3'd2;
  localparam logic [2:0] StShift = 3'd3;
  localparam logic [2:0] StDesel = 3'd4;
  localparam logic [2:0] StGap   = 3'd5;
  localparam logic [2:0] StWait  = 3'd6;
  localparam logic [2:0] StFin   = 3'd7;

  // Kind of the frame currently on the wire
  localparam logic [1:0] FrRead  = 2'd0;
  localparam logic [1:0] FrWren  = 2'd1;
  localparam logic [1:0] FrWrite = 2'd2;
  localparam logic [1:0] FrRdsr  = 2'd3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/eeprom_spi_ctl_shift_engine.sv
// SPI mode-0 shift engine: SCK divider, 32-bit MSB-first transmit shift register, 6-bit bit
// counter and a 2-flop MISO synchroniser with a compensated sample point.
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_load              load i_data (left aligned) and i_nbits; MOSI shows bit 31 immediately
//   i_data, i_nbits     frame contents and length in bits (8/16/32)
//   i_start             begin clocking the loaded frame
//   i_miso              serial data from the device (asynchronous)
//   o_sck, o_mosi       SPI clock (idle low) and data out
//   o_done              one-cycle pulse after the last falling SCK edge
//   o_rx                last 8 bits received
module eeprom_spi_ctl_shift_engine #(
  parameter int unsigned SCK_HALF = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [31:0] i_data,
  input  logic [5:0]  i_nbits,
  input  logic        i_start,
  input  logic        i_miso,
  output logic        o_sck,
  output logic        o_mosi,
  output logic        o_done,
  output logic [7:0]  o_rx
);

  localparam int unsigned DivW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

  logic [DivW-1:0] r_div;
  logic            r_run;
  logic            r_sck;
  logic            r_done;
  logic [31:0]     r_shift;
  logic [5:0]      r_bit;
  logic [5:0]      r_nbits;
  logic [1:0]      r_sync;
  logic [1:0]      r_rise_pipe;
  logic [7:0]      r_rx;
  logic            w_tick;

  assign w_tick = (r_div == DivW'(SCK_HALF - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div       <= '0;
      r_run       <= 1'b0;
      r_sck       <= 1'b0;
      r_done      <= 1'b0;
      r_shift     <= '0;
      r_bit       <= '0;
      r_nbits     <= '0;
      r_sync      <= '0;
      r_rise_pipe <= '0;
      r_rx        <= '0;
    end else begin
      r_sync      <= {r_sync[0], i_miso};
      // Delay the rising-edge marker by the synchroniser depth so the captured bit is the one
      // present on the pin at the rising edge.
      r_rise_pipe <= {r_rise_pipe[0], r_run & w_tick & ~r_sck};
      r_done      <= 1'b0;
      if (r_rise_pipe[1]) begin
        r_rx <= {r_rx[6:0], r_sync[1]};
      end
      if (i_load) begin
        r_shift <= i_data;
        r_nbits <= i_nbits;
      end
      if (i_start) begin
        r_run <= 1'b1;
        r_div <= '0;
        r_bit <= '0;
        r_sck <= 1'b0;
      end else if (r_run) begin
        if (w_tick) begin
          r_div <= '0;
          r_sck <= ~r_sck;
          if (r_sck) begin
            // Falling edge: present the next bit; zeros fill in so MOSI ends low.
            r_shift <= {r_shift[30:0], 1'b0};
            if (r_bit == r_nbits - 6'd1) begin
              r_run  <= 1'b0;
              r_done <= 1'b1;
            end else begin
              r_bit <= r_bit + 6'd1;
            end
          end
        end else begin
          r_div <= r_div + DivW'(1);
        end
      end
    end
  end

  assign o_sck  = r_sck;
  assign o_mosi = r_shift[31];
  assign o_done = r_done;
  assign o_rx   = r_rx;

endmodule

// File: rtl/eeprom_spi_ctl.sv
// Single-byte READ/WRITE controller for a 25xx-series SPI EEPROM with 16-bit addressing.
// Writes are wrapped as WREN frame, WRITE frame, then a write-completion wait. One request in
// flight; lock rejects writes without touching the bus.
// Macro EEPROM_WIP_POLL_EN: when defined the wait polls RDSR until WIP clears (bounded by
// POLL_LIMIT frames, err on timeout); otherwise it is a fixed WR_WAIT-cycle delay.
// Ports:
//   i_clk_dot4x, i_rst_n               clock, asynchronous active-low reset
//   i_req, i_we, i_addr, i_wdata       request and its operands, sampled when o_busy=0
//   i_lock                             1 rejects writes
//   o_busy, o_done, o_err, o_rdata     status, completion pulse, error, read byte
//   o_eeprom_s, o_spi_c, o_spi_d, i_spi_q   SPI pins (CS active low, mode 0)
module eeprom_spi_ctl
  import eeprom_spi_ctl_pkg::*;
#(
  parameter int unsigned SCK_HALF   = 4,
  parameter int unsigned CS_GAP     = 8,
  parameter int unsigned WR_WAIT    = 200000,
  parameter int unsigned POLL_LIMIT = 4095
) (
  input  logic        i_clk_dot4x,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_wdata,
  input  logic        i_lock,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [7:0]  o_rdata,
  output logic        o_eeprom_s,
  output logic        o_spi_c,
  output logic        o_spi_d,
  input  logic        i_spi_q
);

  // One width covers every configured delay or limit.
  localparam int unsigned CntW =
    $clog2(max_u(max_u(SCK_HALF, CS_GAP), max_u(WR_WAIT, POLL_LIMIT)) + 1);

  logic [2:0]      r_state, w_state_nxt;
  logic [1:0]      r_frame, w_frame_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic            r_err, w_err_nxt;
  logic [7:0]      r_rdata, w_rdata_nxt;
  logic [15:0]     r_addr;
  logic [7:0]      r_wdata;
  logic            w_accept;
  logic            w_load;
  logic [31:0]     w_load_data;
  logic [5:0]      w_load_bits;
  logic            w_start;
  logic            w_eng_done;
  logic [7:0]      w_rx;
`ifdef EEPROM_WIP_POLL_EN
  localparam int unsigned PollW = $clog2(POLL_LIMIT + 1);
  logic [PollW-1:0] r_poll, w_poll_nxt;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_frame_nxt = r_frame;
    w_cnt_nxt   = (r_cnt != '0) ? r_cnt - CntW'(1) : r_cnt;
    w_err_nxt   = r_err;
    w_rdata_nxt = r_rdata;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_load_data = '0;
    w_load_bits = '0;
    w_start     = 1'b0;
`ifdef EEPROM_WIP_POLL_EN
    w_poll_nxt  = r_poll;
`endif
    case (r_state)
      StIdle, StFin: begin
        w_state_nxt = StIdle;
        if (i_req) begin
          w_accept  = 1'b1;
          w_err_nxt = 1'b0;
          if (i_we && i_lock) begin
            w_state_nxt = StRej;
          end else begin
            w_state_nxt = StSel;
            w_cnt_nxt   = CntW'(SCK_HALF - 1);
            w_load      = 1'b1;
            if (i_we) begin
              w_frame_nxt = FrWren;
              w_load_data = {EE_OP_WREN, 24'h0};
              w_load_bits = 6'd8;
            end else begin
              w_frame_nxt = FrRead;
              w_load_data = {EE_OP_READ, i_addr, 8'h00};
              w_load_bits = 6'd32;
            end
          end
        end
      end
      StRej: begin
        w_err_nxt   = 1'b1;
        w_state_nxt = StFin;
      end
      StSel: begin
        if (r_cnt == '0) begin
          w_start     = 1'b1;
          w_state_nxt = StShift;
        end
      end
      StShift: begin
        if (w_eng_done) begin
          w_state_nxt = StDesel;
          w_cnt_nxt   = CntW'(SCK_HALF - 1);
        end
      end
      StDesel: begin
        if (r_cnt == '0) begin
          w_state_nxt = StGap;
          w_cnt_nxt   = CntW'(CS_GAP - 1);
        end
      end
      StGap: begin
        if (r_cnt == '0) begin
          case (r_frame)
            FrRead: begin
              w_rdata_nxt = w_rx;
              w_state_nxt = StFin;
            end
            FrWren: begin
              w_frame_nxt = FrWrite;
              w_state_nxt = StSel;
              w_cnt_nxt   = CntW'(SCK_HALF - 1);
              w_load      = 1'b1;
              w_load_data = {EE_OP_WRITE, r_addr, r_wdata};
              w_load_bits = 6'd32;
            end
            FrWrite: begin
              w_state_nxt = StWait;
              w_cnt_nxt   = CntW'(WR_WAIT - 1);
            end
`ifdef EEPROM_WIP_POLL_EN
            FrRdsr: begin
              if (!w_rx[0]) begin
                w_state_nxt = StFin;
              end else if (r_poll == PollW'(POLL_LIMIT - 1)) begin
                w_err_nxt   = 1'b1;
                w_state_nxt = StFin;
              end else begin
                w_poll_nxt  = r_poll + PollW'(1);
                w_state_nxt = StSel;
                w_cnt_nxt   = CntW'(SCK_HALF - 1);
                w_load      = 1'b1;
                w_load_data = {EE_OP_RDSR, 24'h0};
                w_load_bits = 6'd16;
              end
            end
`endif
            default: w_state_nxt = StFin;
          endcase
        end
      end
      StWait: begin
`ifdef EEPROM_WIP_POLL_EN
        w_poll_nxt  = '0;
        w_frame_nxt = FrRdsr;
        w_state_nxt = StSel;
        w_cnt_nxt   = CntW'(SCK_HALF - 1);
        w_load      = 1'b1;
        w_load_data = {EE_OP_RDSR, 24'h0};
        w_load_bits = 6'd16;
`else
        // CS stays high; the device finishes its internal write cycle.
        if (r_cnt == '0) begin
          w_state_nxt = StFin;
        end
`endif
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk_dot4x or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_frame <= FrRead;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_rdata <= 8'h00;
      r_addr  <= '0;
      r_wdata <= '0;
`ifdef EEPROM_WIP_POLL_EN
      r_poll  <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_frame <= w_frame_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
      r_rdata <= w_rdata_nxt;
`ifdef EEPROM_WIP_POLL_EN
      r_poll  <= w_poll_nxt;
`endif
      if (w_accept) begin
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end
    end
  end

  eeprom_spi_ctl_shift_engine #(
    .SCK_HALF(SCK_HALF)
  ) u_engine (
    .i_clk   (i_clk_dot4x),
    .i_rst_n (i_rst_n),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_nbits (w_load_bits),
    .i_start (w_start),
    .i_miso  (i_spi_q),
    .o_sck   (o_spi_c),
    .o_mosi  (o_spi_d),
    .o_done  (w_eng_done),
    .o_rx    (w_rx)
  );

  assign o_busy     = (r_state != StIdle) && (r_state != StFin);
  assign o_done     = (r_state == StFin);
  assign o_err      = r_err & o_done;
  assign o_rdata    = r_rdata;
  assign o_eeprom_s = !((r_state == StSel) || (r_state == StShift) || (r_state == StDesel));

endmodule

// File: tb/tb_eeprom_spi_ctl.sv
// Self-checking bench for eeprom_spi_ctl with a behavioural 25xx EEPROM on the SPI pins.
module tb_eeprom_spi_ctl;

  localparam int unsigned SckHalf   = 4;
  localparam int unsigned CsGap     = 8;
  localparam int unsigned WrWait    = 300;
  localparam int unsigned PollLimit = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic        lock = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic        busy, done, err;
  logic [7:0]  rdata;
  logic        cs_n, sck, mosi;
  logic        miso = 1'b0;

  always #5 clk = ~clk;

  eeprom_spi_ctl #(
    .SCK_HALF  (SckHalf),
    .CS_GAP    (CsGap),
    .WR_WAIT   (WrWait),
    .POLL_LIMIT(PollLimit)
  ) dut (
    .i_clk_dot4x(clk),
    .i_rst_n    (rst_n),
    .i_req      (req),
    .i_we       (we),
    .i_addr     (addr),
    .i_wdata    (wdata),
    .i_lock     (lock),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err),
    .o_rdata    (rdata),
    .o_eeprom_s (cs_n),
    .o_spi_c    (sck),
    .o_spi_d    (mosi),
    .i_spi_q    (miso)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- behavioural EEPROM ----------------
  logic [7:0]  mem [0:65535];
  logic [31:0] m_sr = '0;
  int          m_bits = 0;
  logic [7:0]  m_out = '0;
  logic        m_wel = 1'b0;
  int          m_wip = 0;
  int          m_wip_init = 0;
  int          cs_falls = 0;
  int          cs_rise_cyc = 0;
  int          fr_bits[$];
  logic [31:0] fr_word[$];
  logic        p_sck = 1'b0;
  logic        p_cs = 1'b1;

  always @(sck or cs_n) begin
    if (cs_n === 1'b0 && p_cs === 1'b1) begin
      cs_falls++;
      m_bits = 0;
      m_sr   = '0;
      m_out  = '0;
    end else if (cs_n === 1'b1 && p_cs === 1'b0) begin
      fr_bits.push_back(m_bits);
      fr_word.push_back(m_sr);
      cs_rise_cyc = cyc;
      if (m_bits == 8 && m_sr[7:0] == 8'h06) m_wel = 1'b1;
      if (m_bits == 32 && m_sr[31:24] == 8'h02 && m_wel) begin
        mem[m_sr[23:8]] = m_sr[7:0];
        m_wel = 1'b0;
        m_wip = m_wip_init;
      end else if (m_bits == 16 && m_sr[15:8] == 8'h05 && m_wip > 0) begin
        m_wip--;
      end
    end
    if (cs_n === 1'b0 && sck === 1'b1 && p_sck === 1'b0) begin
      m_sr = {m_sr[30:0], mosi};
      m_bits++;
      if (m_bits == 8 && m_sr[7:0] == 8'h05) m_out = {6'b0, m_wel, (m_wip != 0)};
      if (m_bits == 24 && m_sr[23:16] == 8'h03) m_out = mem[m_sr[15:0]];
    end
    if (cs_n === 1'b0 && sck === 1'b0 && p_sck === 1'b1) begin
      miso  = m_out[7];
      m_out = {m_out[6:0], 1'b0};
    end
    p_sck = sck;
    p_cs  = cs_n;
  end

  function automatic int count_op(input logic [7:0] op, input int nbits);
    int n = 0;
    foreach (fr_bits[i]) begin
      if (fr_bits[i] == nbits && fr_word[i][nbits-1 -: 8] == op) n++;
    end
    return n;
  endfunction

  function automatic logic [31:0] word_at(input int idx);
    return (idx < fr_word.size()) ? fr_word[idx] : 32'hxxxx_xxxx;
  endfunction

  function automatic int bits_at(input int idx);
    return (idx < fr_bits.size()) ? fr_bits[idx] : -1;
  endfunction

  task automatic clear_log();
    fr_bits.delete();
    fr_word.delete();
  endtask

  // Issue one request; req stays high for 'hold' cycles. Waits for done within 'limit' cycles.
  task automatic run_txn(input logic t_we, input logic [15:0] t_addr, input logic [7:0] t_wdata,
                         input logic t_lock, input int hold, input int limit,
                         output logic got_done, output logic t_err, output int n_cyc,
                         output logic busy1, output int done_cyc);
    @(negedge clk);
    we = t_we; addr = t_addr; wdata = t_wdata; lock = t_lock; req = 1'b1;
    got_done = 1'b0; t_err = 1'b0; n_cyc = 0; busy1 = 1'b0; done_cyc = 0;
    while (!got_done && n_cyc < limit) begin
      @(negedge clk);
      n_cyc++;
      if (n_cyc == 1) busy1 = busy;
      if (n_cyc >= hold) req = 1'b0;
      if (done) begin
        got_done = 1'b1;
        t_err    = err;
        done_cyc = cyc;
      end
    end
    req = 1'b0;
    if (!got_done) $display("FAIL txn_timeout: got no done within %0d cycles", limit);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  logic gd, ge, b1;
  int   nc, dc, falls0, good_reach;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'hFF;
    mem[16'h0102] = 8'hA5;

    repeat (3) @(negedge clk);
    check("rst_busy",  busy,  1'b0);
    check("rst_done",  done,  1'b0);
    check("rst_err",   err,   1'b0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_cs",    cs_n,  1'b1);
    check("rst_sck",   sck,   1'b0);
    check("rst_mosi",  mosi,  1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Read 0x0102
    clear_log();
    run_txn(1'b0, 16'h0102, 8'h00, 1'b0, 1, 3000, gd, ge, nc, b1, dc);
    check("rd_done",   gd, 1'b1);
    check("rd_busy1",  b1, 1'b1);
    check("rd_err",    ge, 1'b0);
    check("rd_data",   rdata, 8'hA5);
    check("rd_frames", fr_bits.size(), 1);
    check("rd_mosi",   word_at(0), 32'h0301_0200);
    check("rd_clks",   bits_at(0), 32);
    repeat (4) @(negedge clk);

    // Write 0x003F <= 0x5C
    clear_log();
    m_wip_init = 0;
    run_txn(1'b1, 16'h003F, 8'h5C, 1'b0, 1, 5000, gd, ge, nc, b1, dc);
    check("wr_done",   gd, 1'b1);
    check("wr_err",    ge, 1'b0);
    check("wr_wren",   word_at(0) & 32'h0000_00FF, 32'h0000_0006);
    check("wr_wren_n", bits_at(0), 8);
    check("wr_frame",  word_at(1), 32'h0200_3F5C);
    check("wr_mem",    mem[16'h003F], 8'h5C);
`ifdef EEPROM_WIP_POLL_EN
    check("wr_nframes", fr_bits.size(), 3);
`else
    check("wr_nframes", fr_bits.size(), 2);
    check("wr_waitlen", (dc - cs_rise_cyc) >= int'(WrWait), 1'b1);
`endif
    repeat (4) @(negedge clk);

    clear_log();
    run_txn(1'b0, 16'h003F, 8'h00, 1'b0, 1, 3000, gd, ge, nc, b1, dc);
    check("rb_data", rdata, 8'h5C);
    check("rb_err",  ge, 1'b0);
    repeat (4) @(negedge clk);

    // Locked write: no bus activity, done+err two cycles after req
    falls0 = cs_falls;
    run_txn(1'b1, 16'h0010, 8'h77, 1'b1, 1, 100, gd, ge, nc, b1, dc);
    check("lk_done_cyc", nc, 2);
    check("lk_busy1",    b1, 1'b1);
    check("lk_err",      ge, 1'b1);
    check("lk_cs",       cs_falls - falls0, 0);
    check("lk_mem",      mem[16'h0010], 8'hFF);
    check("lk_rdata",    rdata, 8'h5C);
    lock = 1'b0;
    repeat (4) @(negedge clk);

`ifdef EEPROM_WIP_POLL_EN
    // Device busy for three status reads
    clear_log();
    m_wip_init = 3;
    run_txn(1'b1, 16'h0200, 8'h11, 1'b0, 1, 10000, gd, ge, nc, b1, dc);
    check("poll_done",   gd, 1'b1);
    check("poll_err",    ge, 1'b0);
    check("poll_frames", count_op(8'h05, 16), 4);
    repeat (4) @(negedge clk);

    // Device stuck busy: timeout
    clear_log();
    m_wip_init = 1000;
    run_txn(1'b1, 16'h0201, 8'h22, 1'b0, 1, 20000, gd, ge, nc, b1, dc);
    check("to_done",   gd, 1'b1);
    check("to_err",    ge, 1'b1);
    check("to_frames", count_op(8'h05, 16), PollLimit);
    m_wip = 0;
    m_wip_init = 0;
    repeat (4) @(negedge clk);
`endif

    // Reset during the read address byte
    @(negedge clk);
    we = 1'b0; addr = 16'h0102; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    good_reach = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (cs_n === 1'b0 && m_bits >= 12) begin
        good_reach = 1;
        break;
      end
    end
    check("ab_reach", good_reach, 1);
    rst_n = 1'b0;
    #1;
    check("ab_cs",   cs_n, 1'b1);
    check("ab_sck",  sck,  1'b0);
    check("ab_busy", busy, 1'b0);
    check("ab_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    clear_log();
    run_txn(1'b0, 16'h0102, 8'h00, 1'b0, 1, 3000, gd, ge, nc, b1, dc);
    check("ab_rd_data", rdata, 8'hA5);
    check("ab_rd_err",  ge, 1'b0);
    check("ab_rd_mosi", word_at(0), 32'h0301_0200);
    repeat (4) @(negedge clk);

    // req held high while busy: one transaction only
    clear_log();
    falls0 = cs_falls;
    run_txn(1'b0, 16'h003F, 8'h00, 1'b0, 40, 3000, gd, ge, nc, b1, dc);
    repeat (30) @(negedge clk);
    check("hold_data",   rdata, 8'h5C);
    check("hold_falls",  cs_falls - falls0, 1);
    check("hold_frames", fr_bits.size(), 1);
    check("hold_busy",   busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
